dequantize: RTL and testbench

- Reconstructs an 18-bit sample from an Nquant-bit quantized code. It is the inverse of the requantize stage.
- Takes a right-aligned code and shifts it left, bit-serially, by 18-Nquant positions.
- Adds a half-LSB mid-point reconstruction offset, then presents the result with a one-cycle valid strobe.
- Sits on the decode/playback path, consuming the codes that requantize produces.

---
 rtl/dequantize_pkg.sv | 34 +++
 rtl/dequantize_if.sv | 33 +++
 rtl/dequantize.sv | 121 ++++++++++++
 tb/tb_dequantize.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dequantize_pkg.sv
// -----------------------------------------------------------------------------
// dequantize_pkg
//   Definitions shared by the requantize/dequantize pair.
//   - DW      : sample width (18)
//   - NQW     : width of the Nquant field (5)
//   - NQ_MAX  : largest meaningful Nquant; larger values clamp to it
//   - dq_state_t : 2-bit FSM state encoding
//   - nq_of / sh_of : Nquant clamp and left-shift amount
// -----------------------------------------------------------------------------
package dequantize_pkg;

  localparam int DW     = 18;
  localparam int NQW    = 5;
  localparam int NQ_MAX = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } dq_state_t;

  // Effective number of code bits: anything above NQ_MAX is treated as NQ_MAX.
  function automatic logic [NQW-1:0] nq_of(input logic [NQW-1:0] nquant);
    if (nquant > NQW'(NQ_MAX)) return NQW'(NQ_MAX);
    else                       return nquant;
  endfunction

  // Left-shift distance that moves a right-aligned code to the MSB end.
  function automatic logic [NQW-1:0] sh_of(input logic [NQW-1:0] nquant);
    return NQW'(NQ_MAX) - nq_of(nquant);
  endfunction

endpackage

// File: rtl/dequantize_if.sv
// -----------------------------------------------------------------------------
// dequantize_if
//   Code-in / sample-out bus of the dequantizer.
//   master : the producer of codes (drives Nquant, datain, endatain)
//   slave  : the dequantizer (drives dataout, endataout, busy)
//   Nquant    - number of valid code bits
//   datain    - right-aligned quantized code
//   endatain  - request to start a conversion
//   dataout   - reconstructed sample, held until the next result
//   endataout - one-cycle strobe marking a new dataout
//   busy      - conversion in progress
// -----------------------------------------------------------------------------
interface dequantize_if;
  import dequantize_pkg::*;

  logic [NQW-1:0] Nquant;
  logic [DW-1:0]  datain;
  logic           endatain;
  logic [DW-1:0]  dataout;
  logic           endataout;
  logic           busy;

  modport master (
    output Nquant, datain, endatain,
    input  dataout, endataout, busy
  );

  modport slave (
    input  Nquant, datain, endatain,
    output dataout, endataout, busy
  );

endinterface

// File: rtl/dequantize.sv
// -----------------------------------------------------------------------------
// dequantize
//   Rebuilds an 18-bit sample from an Nquant-bit right-aligned code by shifting
//   it left one bit per cycle, then optionally adding a half-LSB mid-point
//   offset so the reconstruction lands in the centre of the quantization bin.
//
//   Ports
//     clock - rising-edge clock
//     reset - synchronous, active-low; aborts any conversion in progress
//     bus   - dequantize_if.slave (Nquant/datain/endatain in,
//             dataout/endataout/busy out)
//
//   Parameter
//     MIDPOINT - 1: add 2^(sh-1) after shifting; 0: plain left shift
//
//   Timing: a request accepted at edge k yields endataout after edge k+sh+2,
//   with sh = 18 - min(Nquant,18). A new request may be accepted in the same
//   cycle that endataout is high.
// -----------------------------------------------------------------------------
module dequantize
  import dequantize_pkg::*;
#(
  parameter bit MIDPOINT = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  dequantize_if.slave  bus
);

  dq_state_t      r_state;
  logic [DW-1:0]  r_sr;
  logic [NQW-1:0] r_sh;
  logic [NQW-1:0] r_cnt;
  logic [DW-1:0]  r_dataout;
  logic           r_endataout;
  logic           r_busy;

  logic [NQW-1:0] w_nq;
  logic [NQW-1:0] w_sh;
  logic [DW-1:0]  w_code;
  logic [NQW-1:0] w_cnt_nxt;

  // Keep only the low nq bits of the code; nq is already clamped to DW.
  function automatic logic [DW-1:0] code_mask(input logic [NQW-1:0] nq);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < DW; i++) begin
      m[i] = (NQW'(i) < nq);
    end
    return m;
  endfunction

  // Half of one output LSB step for a given shift; zero when nothing was
  // shifted out (full-width code) or when mid-point reconstruction is off.
  function automatic logic [DW-1:0] round_offset(input logic [NQW-1:0] sh);
    logic [DW-1:0] one;
    one = DW'(1);
    if (MIDPOINT && (sh != '0)) return one << (sh - NQW'(1));
    else                        return '0;
  endfunction

  assign w_nq      = nq_of(bus.Nquant);
  assign w_sh      = sh_of(bus.Nquant);
  assign w_code    = bus.datain & code_mask(w_nq);
  assign w_cnt_nxt = r_cnt + NQW'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_dataout   <= '0;
      r_endataout <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_endataout <= 1'b0;
      case (r_state)
        // Accept: capture masked code and shift distance; the inputs are not
        // looked at again until the next return to IDLE.
        ST_IDLE: begin
          if (bus.endatain) begin
            r_sr    <= w_code;
            r_sh    <= w_sh;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= (w_sh != '0) ? ST_SHIFT : ST_ROUND;
          end
        end

        // One bit per cycle, zero fill from the LSB end.
        ST_SHIFT: begin
          r_sr  <= {r_sr[DW-2:0], 1'b0};
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == r_sh) r_state <= ST_ROUND;
        end

        // The shifted-out positions are all zero, so adding 2^(sh-1) cannot
        // carry past bit DW-1.
        ST_ROUND: begin
          r_sr    <= r_sr + round_offset(r_sh);
          r_state <= ST_OUT;
        end

        ST_OUT: begin
          r_dataout   <= r_sr;
          r_endataout <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dataout   = r_dataout;
  assign bus.endataout = r_endataout;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_dequantize.sv
module tb_dequantize;
  import dequantize_pkg::*;

  logic clk;
  logic rst_n;

  dequantize_if bus ();

  dequantize #(.MIDPOINT(1'b1)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  nquant;
    logic [17:0] datain;
    logic [17:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  int tests;
  int failed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One isolated conversion; returns strobe latency (edges after accept),
  // the sample, whether busy stayed high until the strobe, and busy at strobe.
  task automatic convert(input logic [4:0] nq, input logic [17:0] din,
                         output int lat, output logic [17:0] dout,
                         output bit busy_ok, output logic busy_at_out);
    @(negedge clk);
    bus.Nquant   = nq;
    bus.datain   = din;
    bus.endatain = 1'b1;
    @(posedge clk);
    #1;
    bus.endatain = 1'b0;
    lat = 0;
    busy_ok = bus.busy;
    busy_at_out = 1'bx;
    dout = '0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.endataout) begin
        dout = bus.dataout;
        busy_at_out = bus.busy;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    logic [17:0] dout;
    bit          busy_ok;
    logic        busy_at_out;
    int          nstb;
    int          pos;

    tests  = 0;
    failed = 0;

    vecs[0] = '{5'd8,  18'h000A5, 18'h29600, 12};
    vecs[1] = '{5'd18, 18'h2ABCD, 18'h2ABCD, 2};
    vecs[2] = '{5'd4,  18'h3FFFF, 18'h3E000, 16};
    vecs[3] = '{5'd1,  18'h00001, 18'h30000, 19};
    vecs[4] = '{5'd0,  18'h3FFFF, 18'h20000, 20};
    vecs[5] = '{5'd25, 18'h12345, 18'h12345, 2};
    vecs[6] = '{5'd31, 18'h3FFFF, 18'h3FFFF, 2};
    vecs[7] = '{5'd17, 18'h3FFFF, 18'h3FFFF, 3};
    vecs[8] = '{5'd12, 18'h00ABC, 18'h2AF20, 8};

    bus.Nquant   = '0;
    bus.datain   = '0;
    bus.endatain = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dataout",   32'(bus.dataout),   32'h0);
    check("rst_endataout", 32'(bus.endataout), 32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of isolated conversions
    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].nquant, vecs[i].datain, lat, dout, busy_ok, busy_at_out);
      check($sformatf("v%0d_data", i), 32'(dout), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_lat", i),  32'(lat),  32'(vecs[i].exp_lat));
      check($sformatf("v%0d_busy", i), 32'(busy_ok), 32'h1);
      check($sformatf("v%0d_busy_out", i), 32'(busy_at_out), 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_strobe_1cyc", i), 32'(bus.endataout), 32'h0);
    end

    // endatain held high, Nquant=16 (sh=2): a result every 5 edges
    @(negedge clk);
    bus.Nquant   = 5'd16;
    bus.datain   = 18'h0ABCD;
    bus.endatain = 1'b1;
    nstb = 0;
    for (int e = 0; e < 22; e++) begin
      @(posedge clk);
      #1;
      if (bus.endataout) begin
        check($sformatf("b2b_pos%0d", nstb), 32'(e), 32'(4 + 5 * nstb));
        check($sformatf("b2b_data%0d", nstb), 32'(bus.dataout), 32'h2AF36);
        nstb++;
      end
    end
    check("b2b_count", 32'(nstb), 32'd4);
    @(negedge clk);
    bus.endatain = 1'b0;
    repeat (8) @(posedge clk);

    // Requests and Nquant/datain changes while busy are ignored
    @(negedge clk);
    bus.Nquant   = 5'd8;
    bus.datain   = 18'h000A5;
    bus.endatain = 1'b1;
    @(posedge clk);
    #1;
    bus.endatain = 1'b0;
    nstb = 0;
    pos  = -1;
    dout = '0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      bus.endatain = (e == 4) || (e == 9);
      if (e == 4) begin
        bus.Nquant = 5'd1;
        bus.datain = 18'h3FFFF;
      end
      @(posedge clk);
      #1;
      if (bus.endataout) begin
        nstb++;
        pos  = e;
        dout = bus.dataout;
      end
    end
    bus.endatain = 1'b0;
    check("busy_ign_count", 32'(nstb), 32'd1);
    check("busy_ign_pos",   32'(pos),  32'd12);
    check("busy_ign_data",  32'(dout), 32'h29600);

    // Reset in the middle of SHIFT aborts without a strobe
    @(negedge clk);
    bus.Nquant   = 5'd8;
    bus.datain   = 18'h000FF;
    bus.endatain = 1'b1;
    @(posedge clk);
    #1;
    bus.endatain = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_dataout",   32'(bus.dataout),   32'h0);
    check("abort_busy",      32'(bus.busy),      32'h0);
    check("abort_endataout", 32'(bus.endataout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nstb = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (bus.endataout || bus.busy) nstb++;
    end
    check("abort_quiet", 32'(nstb), 32'd0);
    convert(5'd8, 18'h000A5, lat, dout, busy_ok, busy_at_out);
    check("post_rst_data", 32'(dout), 32'h29600);
    check("post_rst_lat",  32'(lat),  32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
